// File: rtl/psram_byte_requester.sv
// psram_byte_requester: CPU-side initiator for one PSRAM byte port.
// Optional read timeout when PSRAM_BYTE_REQUESTER_TIMEOUT_EN is defined.
module psram_byte_requester #(
   parameter int WFIFO_DEPTH = 4,
   parameter int RD_TIMEOUT  = 63
) (
   input  logic        clk,
   input  logic        n_reset,
   input  logic        cpu_rd,
   input  logic        cpu_wr,
   input  logic [21:0] cpu_address,
   input  logic [7:0]  cpu_wdata,
   output logic        cpu_busy,
   output logic [7:0]  cpu_rdata,
   output logic        cpu_rdata_en,
   output logic        rd,
   output logic        wr,
   input  logic        busy,
   output logic [21:0] address,
   output logic [7:0]  wdata,
   input  logic [7:0]  rdata,
`ifdef PSRAM_BYTE_REQUESTER_TIMEOUT_EN
   input  logic        rdata_en,
   output logic        rd_timeout
`else
   input  logic        rdata_en
`endif
);

   localparam int PW = $clog2(WFIFO_DEPTH);
   localparam int CW = $clog2(WFIFO_DEPTH + 1);

   typedef enum logic [1:0] {IDLE, GUARD, WAIT_RD} state_t;

   state_t        state, state_d;
   logic [29:0]   fifo_mem [WFIFO_DEPTH];
   logic [PW-1:0] wp, rp;
   logic [CW-1:0] cnt;
   logic          rd_pend, first, first_d;
   logic [21:0]   rd_addr, addr_d;
   logic [7:0]    wdata_d, rdata_d;
   logic          wr_d, rd_d, done, pop, push, bypass;
   logic          full, empty, accept_wr, accept_rd;

   assign full      = (cnt == CW'(WFIFO_DEPTH));
   assign empty     = (cnt == '0);
   assign cpu_busy  = full | rd_pend;
   assign accept_wr = cpu_wr & ~cpu_busy;
   assign accept_rd = cpu_rd & ~cpu_wr & ~cpu_busy;
   assign push      = accept_wr & ~bypass;

`ifdef PSRAM_BYTE_REQUESTER_TIMEOUT_EN
   localparam int TW = ($clog2(RD_TIMEOUT + 1) < 6) ? 6 : $clog2(RD_TIMEOUT + 1);
   logic [TW-1:0] tcnt;
   logic          tmo_d;
`endif

   // Next-state and next-output decode; a write arriving at an idle,
   // empty queue bypasses the FIFO so it issues on the following cycle.
   always_comb begin
      state_d = state;
      wr_d    = 1'b0;
      rd_d    = 1'b0;
      addr_d  = address;
      wdata_d = wdata;
      rdata_d = cpu_rdata;
      first_d = 1'b0;
      pop     = 1'b0;
      bypass  = 1'b0;
      done    = 1'b0;
`ifdef PSRAM_BYTE_REQUESTER_TIMEOUT_EN
      tmo_d   = 1'b0;
`endif
      unique case (state)
         IDLE: begin
            if (!busy && !empty) begin
               wr_d              = 1'b1;
               {addr_d, wdata_d} = fifo_mem[rp];
               pop               = 1'b1;
               state_d           = GUARD;
            end else if (!busy && accept_wr) begin
               wr_d    = 1'b1;
               addr_d  = cpu_address;
               wdata_d = cpu_wdata;
               bypass  = 1'b1;
               state_d = GUARD;
            end else if (!busy && rd_pend) begin
               rd_d    = 1'b1;
               addr_d  = rd_addr;
               first_d = 1'b1;
               state_d = WAIT_RD;
            end
         end
         GUARD: state_d = IDLE;
         WAIT_RD: begin
            if (!first && rdata_en) begin
               rdata_d = rdata;
               done    = 1'b1;
               state_d = IDLE;
            end
`ifdef PSRAM_BYTE_REQUESTER_TIMEOUT_EN
            else if (tcnt == TW'(RD_TIMEOUT - 1)) begin
               rdata_d = 8'hFF;
               done    = 1'b1;
               tmo_d   = 1'b1;
               state_d = IDLE;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   // State and port-side output registers.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state        <= IDLE;
         wr           <= 1'b0;
         rd           <= 1'b0;
         address      <= '0;
         wdata        <= '0;
         cpu_rdata    <= '0;
         cpu_rdata_en <= 1'b0;
         first        <= 1'b0;
      end else begin
         state        <= state_d;
         wr           <= wr_d;
         rd           <= rd_d;
         address      <= addr_d;
         wdata        <= wdata_d;
         cpu_rdata    <= rdata_d;
         cpu_rdata_en <= done;
         first        <= first_d;
      end
   end

   // Read-pending flag and latched read address.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         rd_pend <= 1'b0;
         rd_addr <= '0;
      end else if (accept_rd) begin
         rd_pend <= 1'b1;
         rd_addr <= cpu_address;
      end else if (done) begin
         rd_pend <= 1'b0;
      end
   end

   // Write-posting FIFO pointers and occupancy.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (push) wp <= wp + PW'(1);
         if (pop)  rp <= rp + PW'(1);
         if (push && !pop)      cnt <= cnt + CW'(1);
         else if (pop && !push) cnt <= cnt - CW'(1);
      end
   end

   // FIFO storage; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wp] <= {cpu_address, cpu_wdata};
   end

`ifdef PSRAM_BYTE_REQUESTER_TIMEOUT_EN
   // Read timeout counter and its strobe.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         tcnt       <= '0;
         rd_timeout <= 1'b0;
      end else begin
         tcnt       <= (state == WAIT_RD && state_d == WAIT_RD) ? tcnt + TW'(1) : '0;
         rd_timeout <= tmo_d;
      end
   end
`endif

endmodule

// File: tb/tb_psram_byte_requester.sv
// tb_psram_byte_requester: directed + random checks against a queue/memory
// model of the requester and a behavioural PSRAM port.
module tb_psram_byte_requester;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        n_reset;
   logic        cpu_rd, cpu_wr;
   logic [21:0] cpu_address;
   logic [7:0]  cpu_wdata;
   logic        cpu_busy;
   logic [7:0]  cpu_rdata;
   logic        cpu_rdata_en;
   logic        rd, wr, busy;
   logic [21:0] address;
   logic [7:0]  wdata, rdata;
   logic        rdata_en;
`ifdef PSRAM_BYTE_REQUESTER_TIMEOUT_EN
   logic        rd_timeout;
`endif

   always #5 clk = ~clk;

   psram_byte_requester #(.WFIFO_DEPTH(DEPTH), .RD_TIMEOUT(63)) dut (
      .clk(clk), .n_reset(n_reset),
      .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
      .cpu_address(cpu_address), .cpu_wdata(cpu_wdata),
      .cpu_busy(cpu_busy), .cpu_rdata(cpu_rdata),
      .cpu_rdata_en(cpu_rdata_en),
      .rd(rd), .wr(wr), .busy(busy),
      .address(address), .wdata(wdata),
      .rdata(rdata),
`ifdef PSRAM_BYTE_REQUESTER_TIMEOUT_EN
      .rdata_en(rdata_en),
      .rd_timeout(rd_timeout)
`else
      .rdata_en(rdata_en)
`endif
   );

   typedef struct {logic [21:0] a; logic [7:0] d;} wreq_t;

   wreq_t       wq[$];
   logic [7:0]  mmem [logic [21:0]];
   logic [7:0]  pmem [logic [21:0]];
   bit          rdpend, in_wait, hold_busy, wr_prev, en_prev;
   logic [21:0] raddr, port_addr;
   logic [7:0]  last_rdata;
   int          busy_cnt, port_phase, port_delay, fixed_delay;
   int          nvec, nfail, cyc, last_wr, rd_cnt, strobe_cnt;

   function automatic logic [7:0] mget(logic [21:0] a);
      return mmem.exists(a) ? mmem[a] : 8'h00;
   endfunction

   function automatic logic [7:0] pget(logic [21:0] a);
      return pmem.exists(a) ? pmem[a] : 8'h00;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic observe();
      bit eb;
      eb = busy;
      cyc++;
      chk("wr_rd_excl", 32'(wr & rd), 0);
      if (wr) begin
         chk("wr_when_busy", 32'(eb), 0);
         chk("wr_pulse", 32'(wr_prev), 0);
         chk("wr_gap", 32'(cyc - last_wr >= 2), 1);
         chk("wr_expected", 32'(wq.size() != 0), 1);
         if (wq.size() != 0) begin
            chk("wr_addr", 32'(address), 32'(wq[0].a));
            chk("wr_data", 32'(wdata), 32'(wq[0].d));
            void'(wq.pop_front());
         end
         pmem[address] = wdata;
         last_wr = cyc;
      end
      if (rd) begin
         chk("rd_when_busy", 32'(eb), 0);
         chk("rd_after_writes", 32'(wq.size()), 0);
         chk("rd_pending", 32'(rdpend), 1);
         in_wait = 1;
         rd_cnt++;
      end
      if (in_wait) chk("rd_addr_hold", 32'(address), 32'(raddr));
      if (cpu_rdata_en) begin
         chk("strobe_expected", 32'(rdpend), 1);
         chk("strobe_pulse", 32'(en_prev), 0);
         chk("cpu_rdata", 32'(cpu_rdata), 32'(mget(raddr)));
         rdpend = 0;
         in_wait = 0;
         last_rdata = cpu_rdata;
         strobe_cnt++;
      end else begin
         chk("rdata_hold", 32'(cpu_rdata), 32'(last_rdata));
      end
      chk("cpu_busy", 32'(cpu_busy), 32'((wq.size() == DEPTH) || rdpend));
      // behavioural PSRAM port
      if (rd) begin
         port_phase = 1;
         port_addr  = address;
         port_delay = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(1, 6));
         rdata      = 8'($urandom);
      end else if (port_phase == 1) begin
         rdata_en   = 1'b0;
         port_phase = 2;
      end else if (port_phase == 2) begin
         if (port_delay <= 1) begin
            rdata_en   = 1'b1;
            rdata      = pget(port_addr);
            port_phase = 0;
         end else port_delay--;
      end
      if (wr || rd) busy_cnt = $urandom_range(1, 3);
      else if (busy_cnt > 0) busy_cnt--;
      busy    = hold_busy | (busy_cnt > 0);
      wr_prev = wr;
      en_prev = cpu_rdata_en;
   endtask

   task automatic drive(bit w, bit r, logic [21:0] a, logic [7:0] d);
      bit mb;
      cpu_wr = w;
      cpu_rd = r;
      cpu_address = a;
      cpu_wdata = d;
      mb = (wq.size() == DEPTH) || rdpend;
      if (w && !mb) begin
         wq.push_back('{a: a, d: d});
         mmem[a] = d;
      end else if (r && !mb) begin
         rdpend = 1;
         raddr  = a;
      end
   endtask

   task automatic tick(bit w, bit r, logic [21:0] a, logic [7:0] d);
      @(negedge clk);
      observe();
      drive(w, r, a, d);
   endtask

   task automatic reset_model();
      wq.delete();
      rdpend = 0;
      in_wait = 0;
      wr_prev = 0;
      en_prev = 0;
      last_rdata = 8'h00;
      last_wr = cyc - 10;
      mmem = pmem;
   endtask

   task automatic chk_zero(string tag);
      chk({tag, "_wr"}, 32'(wr), 0);
      chk({tag, "_rd"}, 32'(rd), 0);
      chk({tag, "_addr"}, 32'(address), 0);
      chk({tag, "_wdata"}, 32'(wdata), 0);
      chk({tag, "_rdata"}, 32'(cpu_rdata), 0);
      chk({tag, "_rdata_en"}, 32'(cpu_rdata_en), 0);
      chk({tag, "_cpu_busy"}, 32'(cpu_busy), 0);
   endtask

   task automatic drain(string tag);
      int n;
      n = 0;
      while ((wq.size() != 0 || rdpend) && n < 300) begin
         tick(0, 0, '0, '0);
         n++;
      end
      chk(tag, 32'(wq.size() != 0 || rdpend), 0);
   endtask

   initial begin
      int k, r0;
      nvec = 0; nfail = 0; cyc = 0; rd_cnt = 0; strobe_cnt = 0;
      hold_busy = 0; busy_cnt = 0; port_phase = 0; fixed_delay = -1;
      busy = 0; rdata = 0; rdata_en = 0;
      cpu_rd = 0; cpu_wr = 0; cpu_address = '0; cpu_wdata = '0;
      n_reset = 0;
      reset_model();
      repeat (3) @(negedge clk);
      chk_zero("reset");
      n_reset = 1;

      // single write, minimum latency
      tick(1, 0, 22'h000123, 8'hA5);
      tick(0, 0, '0, '0);
      chk("wr_latency", 32'(wr), 1);
      chk("wr1_addr", 32'(address), 32'h000123);
      chk("wr1_data", 32'(wdata), 32'hA5);

      // fill FIFO while port busy, fifth write dropped
      hold_busy = 1;
      repeat (4) tick(0, 0, '0, '0);
      for (int i = 0; i < 5; i++) tick(1, 0, 22'(32 + i), 8'(8'h40 + i));
      chk("fifo_full", 32'(cpu_busy), 1);
      tick(0, 0, '0, '0);
      hold_busy = 0;
      drain("drain_fifo");

      // write then immediate read of same byte, fixed port latency
      fixed_delay = 5;
      tick(1, 0, 22'h000010, 8'h11);
      tick(0, 1, 22'h000010, 8'h00);
      k = strobe_cnt;
      drain("drain_raw");
      chk("raw_strobes", 32'(strobe_cnt - k), 1);
      chk("raw_rdata", 32'(last_rdata), 32'h11);

      // rdata_en still high from last read: must wait for fresh strobe
      chk("stale_en_setup", 32'(rdata_en), 1);
      tick(0, 1, 22'h000123, 8'h00);
      drain("drain_stale");
      chk("stale_rdata", 32'(last_rdata), 32'hA5);
      fixed_delay = -1;

      // simultaneous rd and wr: only the write counts
      k = rd_cnt; r0 = strobe_cnt;
      tick(1, 1, 22'h000200, 8'h5C);
      repeat (20) tick(0, 0, '0, '0);
      chk("simul_no_rd", 32'(rd_cnt - k), 0);
      chk("simul_no_strobe", 32'(strobe_cnt - r0), 0);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         if (i % 40 == 0) hold_busy = ($urandom_range(0, 3) == 0);
         tick($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
              22'($urandom_range(0, 15)), 8'($urandom));
      end
      hold_busy = 0;
      drain("drain_random");

      // reset asserted in the middle of a read
      tick(0, 1, 22'h000007, 8'h00);
      k = 0;
      while (!in_wait && k < 30) begin
         tick(0, 0, '0, '0);
         k++;
      end
      chk("mid_reset_reached_wait", 32'(in_wait), 1);
      @(negedge clk);
      n_reset = 0;
      #1;
      chk_zero("mid_reset");
      reset_model();
      @(negedge clk);
      n_reset = 1;
      r0 = strobe_cnt;
      repeat (15) tick(0, 0, '0, '0);
      chk("post_reset_no_strobe", 32'(strobe_cnt - r0), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule
